// File: rtl/combo_lock_driver.sv
// combo_lock_driver: automated operator for the 4-bit combination lock.
// Takes OPEN / CHANGE / RELOCK commands, performs timed switch setup and
// enter/change presses on the lock, then decodes the lock's 7-segment
// display to report one result per command.
module combo_lock_driver #(
  parameter int SETUP_CYCLES = 4,  // switch stable before a press (1..255)
  parameter int PRESS_CYCLES = 4,  // button high time per press (1..255)
  parameter int GAP_CYCLES   = 4   // button low time before the display is judged (1..255)
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_code,
  input  logic [3:0] cmd_new,
  input  logic [0:6] leds,
  output logic [3:0] switch,
  output logic       enter,
  output logic       change,
  output logic       rsp_valid,
  output logic [2:0] rsp_status,
  output logic       busy
);

  // Controller states
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PRECHECK = 3'd1;
  localparam logic [2:0] S_SETUP    = 3'd2;
  localparam logic [2:0] S_PRESS    = 3'd3;
  localparam logic [2:0] S_GAP      = 3'd4;
  localparam logic [2:0] S_RESP     = 3'd5;

  // Command opcodes
  localparam logic [1:0] OP_OPEN   = 2'b00;
  localparam logic [1:0] OP_CHANGE = 2'b01;
  localparam logic [1:0] OP_RELOCK = 2'b10;

  // Decoded display
  localparam logic [2:0] D_UNKNOWN = 3'd0;
  localparam logic [2:0] D_LOCKED  = 3'd1;
  localparam logic [2:0] D_NEW     = 3'd2;
  localparam logic [2:0] D_ALARM   = 3'd3;
  localparam logic [2:0] D_OPEN    = 3'd4;

  // Response codes
  localparam logic [2:0] ST_OK          = 3'd0;
  localparam logic [2:0] ST_BAD_CODE    = 3'd1;
  localparam logic [2:0] ST_ALARM       = 3'd2;
  localparam logic [2:0] ST_BAD_STATE   = 3'd3;
  localparam logic [2:0] ST_NO_RESPONSE = 3'd4;

  // Terminal counts for the 8-bit phase counter
  localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] PRESS_LAST = 8'(PRESS_CYCLES - 1);
  localparam logic [7:0] GAP_LAST   = 8'(GAP_CYCLES - 1);

  logic [2:0] r_state;
  logic [7:0] r_cnt;
  logic       r_press;       // 0 = first press, 1 = second press of CHANGE
  logic [1:0] r_op;
  logic [3:0] r_code;
  logic [3:0] r_new;
  logic [2:0] r_decode;
  logic [3:0] r_switch;
  logic       r_enter;
  logic       r_change;
  logic       r_rsp_valid;
  logic [2:0] r_rsp_status;

  logic [2:0] w_decode;
  logic       w_pre_ok;
  logic [2:0] w_pre_status;
  logic       w_chk_again;
  logic [2:0] w_chk_status;

  // Classify the raw display pattern (registered below as r_decode)
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_decode = D_UNKNOWN;
    case (leds)
      7'b1111110: w_decode = D_LOCKED;
      7'b1101010: w_decode = D_NEW;
      7'b0001000: w_decode = D_ALARM;
      7'b0000001: w_decode = D_OPEN;
      default:    w_decode = D_UNKNOWN;
    endcase
  end

  // Pre-press check: alarm first, then the lock state each op requires
  always_comb begin
    w_pre_ok     = 1'b0;
    w_pre_status = ST_BAD_STATE;
    if (r_decode == D_ALARM) begin
      w_pre_status = ST_ALARM;
    end else begin
      case (r_op)
        OP_OPEN, OP_CHANGE: w_pre_ok = (r_decode == D_LOCKED);
        OP_RELOCK:          w_pre_ok = (r_decode == D_OPEN);
        default:            w_pre_ok = 1'b0;
      endcase
    end
  end

  // Post-press judgement of the display; w_chk_again requests CHANGE press 2
  always_comb begin
    w_chk_again  = 1'b0;
    w_chk_status = ST_NO_RESPONSE;
    case (r_op)
      OP_OPEN: begin
        case (r_decode)
          D_OPEN:   w_chk_status = ST_OK;
          D_LOCKED: w_chk_status = ST_BAD_CODE;
          D_ALARM:  w_chk_status = ST_ALARM;
          default:  w_chk_status = ST_NO_RESPONSE;
        endcase
      end
      OP_CHANGE: begin
        if (!r_press) begin
          case (r_decode)
            D_NEW:    w_chk_again  = 1'b1;
            D_LOCKED: w_chk_status = ST_BAD_CODE;
            D_ALARM:  w_chk_status = ST_ALARM;
            default:  w_chk_status = ST_NO_RESPONSE;
          endcase
        end else if (r_decode == D_LOCKED) begin
          w_chk_status = ST_OK;
        end
      end
      OP_RELOCK: begin
        if (r_decode == D_LOCKED) w_chk_status = ST_OK;
      end
      default: w_chk_status = ST_NO_RESPONSE;
    endcase
  end

  // Sequencer: all lock-facing outputs are registered so they change only on
  // clock edges. The display is judged on the edge that ends the last GAP
  // cycle, which makes the accept-to-response latency N*(S+P+G)+2.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state      <= S_IDLE;
      r_cnt        <= 8'd0;
      r_press      <= 1'b0;
      r_op         <= 2'b00;
      r_code       <= 4'd0;
      r_new        <= 4'd0;
      r_decode     <= D_UNKNOWN;
      r_switch     <= 4'd0;
      r_enter      <= 1'b0;
      r_change     <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_status <= ST_OK;
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples
      // pre-edge values, independent of statement order.
      r_decode    <= w_decode;
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_op    <= cmd_op;
            r_code  <= cmd_code;
            r_new   <= cmd_new;
            r_state <= S_PRECHECK;
          end
        end
        S_PRECHECK: begin
          if (w_pre_ok) begin
            r_state <= S_SETUP;
            r_cnt   <= 8'd0;
            r_press <= 1'b0;
            if (r_op != OP_RELOCK) r_switch <= r_code;
          end else begin
            r_state      <= S_RESP;
            r_rsp_valid  <= 1'b1;
            r_rsp_status <= w_pre_status;
          end
        end
        S_SETUP: begin
          if (r_cnt == SETUP_LAST) begin
            r_cnt   <= 8'd0;
            r_state <= S_PRESS;
            if (r_op == OP_CHANGE) r_change <= 1'b1;
            else                   r_enter  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_PRESS: begin
          if (r_cnt == PRESS_LAST) begin
            r_cnt    <= 8'd0;
            r_state  <= S_GAP;
            r_enter  <= 1'b0;
            r_change <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_cnt <= 8'd0;
            if (w_chk_again) begin
              r_state  <= S_SETUP;
              r_press  <= 1'b1;
              r_switch <= r_new;
            end else begin
              r_state      <= S_RESP;
              r_rsp_valid  <= 1'b1;
              r_rsp_status <= w_chk_status;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_RESP: begin
          r_state  <= S_IDLE;
          r_switch <= 4'd0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready  = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign switch     = r_switch;
  assign enter      = r_enter;
  assign change     = r_change;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_status = r_rsp_status;

endmodule

// File: tb/tb_combo_lock_driver.sv
// tb_combo_lock_driver: drives combo_lock_driver against a behavioural model
// of the combination lock and predicts each result from the lock's abstract
// state (locked/open/alarm/new, combination, wrong-try count).
module tb_combo_lock_driver;

  localparam int S = 4;
  localparam int P = 4;
  localparam int G = 4;

  localparam int M_LOCKED = 0;
  localparam int M_OPEN   = 1;
  localparam int M_ALARM  = 2;
  localparam int M_NEW    = 3;

  logic       Clock = 1'b0;
  logic       Resetn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_code = 4'd0;
  logic [3:0] cmd_new = 4'd0;
  logic [0:6] leds;
  logic [3:0] switch;
  logic       enter;
  logic       change;
  logic       rsp_valid;
  logic [2:0] rsp_status;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Lock model state
  int         m_state;
  int         m_wrong;
  logic [3:0] m_combo;
  logic       m_pe;
  logic       m_pc;
  bit         m_reset_req = 1'b0;
  logic [3:0] m_reset_combo = 4'd6;
  bit         m_stuck = 1'b0;

  // Observations of the last command
  int         last_first_ent;
  logic [3:0] last_sw [2];

  always #5 Clock = ~Clock;

  combo_lock_driver #(.SETUP_CYCLES(S), .PRESS_CYCLES(P), .GAP_CYCLES(G)) dut (
    .Clock(Clock), .Resetn(Resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_code(cmd_code), .cmd_new(cmd_new), .leds(leds),
    .switch(switch), .enter(enter), .change(change),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status), .busy(busy)
  );

  // Lock behaviour: reacts to rising edges of enter/change; two wrong codes alarm
  always @(negedge Clock) begin
    m_pe <= enter;
    m_pc <= change;
    if (m_reset_req) begin
      m_state <= M_LOCKED;
      m_wrong <= 0;
      m_combo <= m_reset_combo;
    end else if (enter && !m_pe) begin
      if (m_state == M_LOCKED) begin
        if (switch == m_combo) begin
          m_state <= M_OPEN;
          m_wrong <= 0;
        end else begin
          m_wrong <= m_wrong + 1;
          if (m_wrong + 1 >= 2) m_state <= M_ALARM;
        end
      end else if (m_state == M_OPEN) begin
        m_state <= M_LOCKED;
      end
    end else if (change && !m_pc) begin
      if (m_state == M_LOCKED) begin
        if (switch == m_combo) begin
          m_state <= M_NEW;
        end else begin
          m_wrong <= m_wrong + 1;
          if (m_wrong + 1 >= 2) m_state <= M_ALARM;
        end
      end else if (m_state == M_NEW) begin
        m_combo <= switch;
        m_wrong <= 0;
        m_state <= M_LOCKED;
      end
    end
  end

  // Lock display
  always_comb begin
    leds = 7'b0110000;
    if (m_stuck) leds = 7'b0000000;
    else begin
      case (m_state)
        M_LOCKED: leds = 7'b1111110;
        M_NEW:    leds = 7'b1101010;
        M_ALARM:  leds = 7'b0001000;
        M_OPEN:   leds = 7'b0000001;
        default:  leds = 7'b0110000;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected status/press count from the lock's state before the command
  function automatic void predict(input int st, input logic [3:0] combo, input int wrong,
                                  input logic [1:0] op, input logic [3:0] code,
                                  output int status, output int presses);
    presses = 0;
    status  = 3;
    if (st == M_ALARM) status = 2;
    else if (op == 2'd0 || op == 2'd1) begin
      if (st == M_LOCKED) begin
        if (code == combo) begin
          status  = 0;
          presses = (op == 2'd1) ? 2 : 1;
        end else begin
          presses = 1;
          status  = (wrong + 1 >= 2) ? 2 : 1;
        end
      end
    end else if (op == 2'd2) begin
      if (st == M_OPEN) begin
        status  = 0;
        presses = 1;
      end
    end
  endfunction

  task automatic lock_reset(input logic [3:0] c);
    @(posedge Clock);
    m_reset_combo = c;
    m_reset_req   = 1'b1;
    @(posedge Clock);
    m_reset_req   = 1'b0;
  endtask

  // Issue one command, observe it to completion and compare with the prediction
  task automatic do_cmd(input string tag, input logic [1:0] op, input logic [3:0] code,
                        input logic [3:0] nw, input bit hold, input bit stuck);
    int e_stat, e_pr, cyc, lat, stat, ent, chg, pulses, overlap, pidx;
    bit got;
    logic pe, pc;
    @(negedge Clock);
    predict(m_state, m_combo, m_wrong, op, code, e_stat, e_pr);
    if (stuck) e_stat = 4;
    check({tag, ".ready"}, cmd_ready, 1);
    cmd_op = op; cmd_code = code; cmd_new = nw; cmd_valid = 1'b1;
    cyc = 0; lat = -1; stat = -1; ent = 0; chg = 0; pulses = 0; overlap = 0; pidx = 0;
    got = 1'b0; pe = 1'b0; pc = 1'b0; last_first_ent = 0;
    last_sw[0] = 4'hx; last_sw[1] = 4'hx;
    while (!got && cyc < 200) begin
      @(negedge Clock);
      cyc++;
      if (cyc == 1 && !hold) begin
        cmd_valid = 1'b0;
        cmd_op   = 2'($urandom);
        cmd_code = 4'($urandom);
        cmd_new  = 4'($urandom);
      end
      if (stuck && cyc == S + P + 2) m_stuck = 1'b1;
      if (enter) begin
        ent++;
        if (last_first_ent == 0) last_first_ent = cyc;
      end
      if (change) chg++;
      if (enter && change) overlap++;
      if (((enter && !pe) || (change && !pc)) && pidx < 2) begin
        last_sw[pidx] = switch;
        pidx++;
      end
      pe = enter;
      pc = change;
      if (rsp_valid) begin
        got = 1'b1;
        lat = cyc;
        stat = int'(rsp_status);
        pulses++;
        cmd_valid = 1'b0;
      end
    end
    m_stuck   = 1'b0;
    cmd_valid = 1'b0;
    repeat (6) begin
      @(negedge Clock);
      if (rsp_valid) pulses++;
    end
    check({tag, ".status"}, stat, e_stat);
    check({tag, ".latency"}, lat, e_pr * (S + P + G) + 2);
    check({tag, ".enter_cycles"}, ent, (op == 2'd1) ? 0 : e_pr * P);
    check({tag, ".change_cycles"}, chg, (op == 2'd1) ? e_pr * P : 0);
    check({tag, ".overlap"}, overlap, 0);
    check({tag, ".pulses"}, pulses, 1);
    check({tag, ".status_hold"}, rsp_status, e_stat);
    check({tag, ".switch_idle"}, switch, 0);
  endtask

  initial begin
    int pulses;
    // Reset state
    repeat (3) @(negedge Clock);
    check("rst.ready", cmd_ready, 1);
    check("rst.busy", busy, 0);
    check("rst.switch", switch, 0);
    check("rst.enter", enter, 0);
    check("rst.change", change, 0);
    check("rst.rsp_valid", rsp_valid, 0);
    check("rst.rsp_status", rsp_status, 0);
    Resetn = 1'b1;
    lock_reset(4'd6);

    // Correct OPEN, then RELOCK
    do_cmd("open6", 2'd0, 4'd6, 4'd0, 1'b0, 1'b0);
    check("open6.first_enter_cycle", last_first_ent, 6);
    check("open6.switch", last_sw[0], 6);
    do_cmd("relock1", 2'd2, 4'd0, 4'd0, 1'b0, 1'b0);

    // Wrong codes escalate to alarm; alarm is then reported without a press
    do_cmd("open5a", 2'd0, 4'd5, 4'd0, 1'b0, 1'b0);
    do_cmd("open5b", 2'd0, 4'd5, 4'd0, 1'b0, 1'b0);
    do_cmd("open5c", 2'd0, 4'd5, 4'd0, 1'b0, 1'b0);
    lock_reset(4'd6);

    // CHANGE 6 -> 9, then open with the new code
    do_cmd("change69", 2'd1, 4'd6, 4'd9, 1'b0, 1'b0);
    check("change69.switch1", last_sw[0], 6);
    check("change69.switch2", last_sw[1], 9);
    do_cmd("open9", 2'd0, 4'd9, 4'd0, 1'b0, 1'b0);

    // RELOCK from OPEN succeeds, RELOCK from LOCKED is refused; reserved op
    do_cmd("relock2", 2'd2, 4'd0, 4'd0, 1'b0, 1'b0);
    do_cmd("relock_locked", 2'd2, 4'd0, 4'd0, 1'b0, 1'b0);
    do_cmd("op3", 2'd3, 4'd9, 4'd0, 1'b0, 1'b0);

    // Reset in the middle of a press
    @(negedge Clock);
    cmd_op = 2'd0; cmd_code = 4'd9; cmd_valid = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge Clock);
      if (c == 1) cmd_valid = 1'b0;
    end
    check("midrst.enter_before", enter, 1);
    #2 Resetn = 1'b0;
    #1;
    check("midrst.enter", enter, 0);
    check("midrst.busy", busy, 0);
    @(negedge Clock);
    Resetn = 1'b1;
    pulses = 0;
    repeat (20) begin
      @(negedge Clock);
      if (rsp_valid) pulses++;
    end
    check("midrst.no_rsp", pulses, 0);
    check("midrst.ready", cmd_ready, 1);
    do_cmd("relock3", 2'd2, 4'd0, 4'd0, 1'b0, 1'b0);

    // Display goes blank during the gap
    do_cmd("stuck", 2'd0, 4'd9, 4'd0, 1'b0, 1'b1);
    do_cmd("relock4", 2'd2, 4'd0, 4'd0, 1'b0, 1'b0);

    // cmd_valid held throughout: exactly one response
    do_cmd("hold", 2'd0, 4'd9, 4'd0, 1'b1, 1'b0);
    do_cmd("relock5", 2'd2, 4'd0, 4'd0, 1'b1, 1'b0);

    // Random commands against the lock model
    for (int i = 0; i < 40; i++) begin
      int sel;
      logic [1:0] op;
      logic [3:0] code;
      if (m_state == M_ALARM) lock_reset(m_combo);
      sel = $urandom_range(0, 9);
      op = (sel < 4) ? 2'd0 : (sel < 6) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3;
      code = ($urandom_range(0, 3) == 0) ? 4'($urandom) : m_combo;
      do_cmd($sformatf("rnd%0d", i), op, code, 4'($urandom), bit'($urandom_range(0, 1)), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
